seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 4..65535.
REQ-002 Parameter BLANK, default 4: anti-ghosting cycles at the start of each slot; legal range 0..SCAN_DIV-1.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 hrm, hrl, minm, minl, secm, secl  in  4 each  BCD time digits from the RTC counter chain.
REQ-006 blank_lz  in  1  1 = suppress hrm when it is 0.
REQ-007 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 dp  out  1  decimal point/colon, active-low.
REQ-009 an  out  6  digit enables, one-hot active-low; an[0]=secl … an[5]=hrm.
REQ-010 digit_idx  out  3  index of the slot currently driven, 0..5.
REQ-011 frame_done  out  1  one-cycle pulse at end of each 6-slot frame.

Function
REQ-012 The prescaler counts 0..SCAN_DIV-1 and wraps to 0; tick = (prescaler == SCAN_DIV-1).
REQ-013 Slot index idx advances on tick: 0→1→…→5→0; it holds otherwise.
REQ-014 frame_done = 1 for exactly the cycle after tick with idx==5, 0 otherwise; period = 6*SCAN_DIV cycles.
REQ-015 All six inputs are captured into a snapshot register when idx wraps 5→0 (frame start); inputs are ignored at all other times, so no frame mixes old and new digits.
REQ-016 Slot mapping: idx0=secl, 1=secm, 2=minl, 3=minm, 4=hrl, 5=hrm, taken from the snapshot.
REQ-017 All outputs are registered; outputs in cycle n+1 reflect prescaler/idx/snapshot in cycle n, giving 1-cycle latency.
REQ-018 an: the bit for idx is 0 only while prescaler >= BLANK; all bits are 1 while prescaler < BLANK.
REQ-019 Decode 0-9 as standard 7-seg, e.g. 0=1000000, 1=1111001, 6=0000010, 8=0000000; codes 10-15 give dash 0111111.
REQ-020 With blank_lz=1 and snapshot hrm==0, an[5] stays 1 for the whole of slot 5; seg is still driven.
REQ-021 Blink phase bit toggles at frame start whenever new snapshot secl != previous snapshot secl; it holds otherwise.
REQ-022 dp = 0 (lit) only during slots 2 and 4 with blink phase = 1; dp = 1 otherwise, including during blanking.
REQ-023 digit_idx equals registered idx (1-cycle lag per REQ-017).
REQ-024 rst wins over every other event, including a tick or frame start in the same cycle.

Reset
REQ-025 While rst=1, on each posedge: prescaler=0, idx=0, snapshot=all 0, blink phase=0.
REQ-026 While rst=1, outputs: an=111111, seg=1111111, dp=1, frame_done=0, digit_idx=0.
REQ-027 In the first cycle after rst falls, the prescaler counts from 0 and slot 0 begins; the snapshot stays 0 until the first 5→0 wrap.

Verification (SCAN_DIV=8, BLANK=2)
REQ-028 Hold rst 3 cycles -> an=111111, seg=1111111, dp=1, frame_done=0, digit_idx=0 during and 1 cycle after.
REQ-029 Apply 12:34:56 across 2 frames -> in the second frame, slot 0 shows an=111110, seg=0000010 for 6 cycles after 2 blank cycles. Slot 5 shows seg=1111001. frame_done pulses every 48 cycles.
REQ-030 Change secl 6→7 mid-frame -> slot 0 keeps 0000010 until the next frame start, then shows 1111000. Blink phase toggles, so dp lights in slots 2 and 4.
REQ-031 minl=4'hB -> slot 2 seg=0111111.
REQ-032 hrm=0, blank_lz=1 -> an[5]=1 through all of slot 5; blank_lz=0 -> an[5]=0 with seg=1000000.
REQ-033 Assert rst mid-slot 3 -> next cycle shows REQ-026 values; after release, scan restarts at slot 0 with a full 8-cycle slot.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between the RTC counter chain and the multiplexed 6-digit display.
// master: drives the BCD digits and the leading-zero option; slave: drives the display.
interface seg7_scan_driver_if;
    logic [3:0] hrm;
    logic [3:0] hrl;
    logic [3:0] minm;
    logic [3:0] minl;
    logic [3:0] secm;
    logic [3:0] secl;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic [2:0] digit_idx;
    logic       frame_done;

    modport master (
        output hrm, hrl, minm, minl, secm, secl, blank_lz,
        input  seg, dp, an, digit_idx, frame_done
    );

    modport slave (
        input  hrm, hrl, minm, minl, secm, secl, blank_lz,
        output seg, dp, an, digit_idx, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment scanner with per-frame digit snapshot,
// anti-ghosting blanking, leading-zero suppression and a colon blink phase.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BLANK    = 4
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus
);

    localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] BLANK_CNT = 16'(BLANK);
    localparam logic [2:0]  LAST_SLOT = 3'd5;

    logic [15:0] prescaler_reg;
    logic [15:0] prescaler_next;
    logic [2:0]  idx_reg;
    logic [2:0]  idx_next;
    logic        blink_reg;
    logic        blink_next;
    logic [3:0]  snap_reg  [6];
    logic [3:0]  snap_next [6];
    logic [3:0]  live_digit [6];

    logic        tick;
    logic        frame_start;

    logic [6:0]  seg_reg;
    logic [6:0]  seg_next;
    logic        dp_reg;
    logic        dp_next;
    logic [5:0]  an_reg;
    logic [5:0]  an_next;
    logic [2:0]  digit_idx_reg;
    logic        frame_done_reg;
    logic        frame_done_next;

    logic [3:0]  cur_digit;
    logic        active;
    logic        suppress;
    logic        show;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Slot order: index 0 is the rightmost digit (seconds units).
    assign live_digit[0] = bus.secl;
    assign live_digit[1] = bus.secm;
    assign live_digit[2] = bus.minl;
    assign live_digit[3] = bus.minm;
    assign live_digit[4] = bus.hrl;
    assign live_digit[5] = bus.hrm;

    always_comb begin
        tick           = (prescaler_reg == DIV_LAST);
        frame_start    = tick && (idx_reg == LAST_SLOT);
        prescaler_next = tick ? 16'd0 : prescaler_reg + 16'd1;
        idx_next       = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == LAST_SLOT) ? 3'd0 : idx_reg + 3'd1;
        end
        blink_next = blink_reg ^ (frame_start && (live_digit[0] != snap_reg[0]));
    end

    // Digits are only sampled at the frame boundary so a frame never mixes two times.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_snap
            assign snap_next[gi] = frame_start ? live_digit[gi] : snap_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_reg <= '0;
            idx_reg       <= '0;
            blink_reg     <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            prescaler_reg <= prescaler_next;
            idx_reg       <= idx_next;
            blink_reg     <= blink_next;
            snap_reg      <= snap_next;
        end
    end

    always_comb begin
        case (idx_reg)
            3'd0:    cur_digit = snap_reg[0];
            3'd1:    cur_digit = snap_reg[1];
            3'd2:    cur_digit = snap_reg[2];
            3'd3:    cur_digit = snap_reg[3];
            3'd4:    cur_digit = snap_reg[4];
            3'd5:    cur_digit = snap_reg[5];
            default: cur_digit = snap_reg[0];
        endcase
        active          = (prescaler_reg >= BLANK_CNT);
        suppress        = (idx_reg == LAST_SLOT) && bus.blank_lz && (snap_reg[5] == 4'd0);
        show            = active && !suppress;
        seg_next        = decode(cur_digit);
        dp_next         = !(active && blink_reg && ((idx_reg == 3'd2) || (idx_reg == 3'd4)));
        frame_done_next = frame_start;
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_an
            assign an_next[gi] = !(show && (idx_reg == 3'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg        <= 7'h7F;
            dp_reg         <= 1'b1;
            an_reg         <= 6'h3F;
            digit_idx_reg  <= 3'd0;
            frame_done_reg <= 1'b0;
        end else begin
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
            digit_idx_reg  <= idx_reg;
            frame_done_reg <= frame_done_next;
        end
    end

    assign bus.seg        = seg_reg;
    assign bus.dp         = dp_reg;
    assign bus.an         = an_reg;
    assign bus.digit_idx  = digit_idx_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
